// File: rtl/exec_muldiv.sv
// exec_muldiv: iterative multiply/divide unit (one bit per cycle) with architectural HI/LO registers
module exec_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             kill_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] acc, acc_nx, fixed;
  logic [WIDTH-1:0] b_mag, a_mag, b_in_mag, rem_f, quo_f;
  logic [WIDTH:0] add_sum, trial;
  logic is_div, neg_a, neg_b, b_zero, issue, idle_issue, start, sgn_op, commit;
  assign busy_o = state != IDLE;
  assign issue = valid_i & ~kill_i;
  assign stall_o = busy_o & issue;
  assign idle_issue = issue & ~busy_o;
  assign start = idle_issue & ~op_i[2];
  assign sgn_op = ~op_i[0];
  assign commit = state == FIX && !kill_i;
  assign result_o = (valid_i && !busy_o && op_i == 3'b100) ? hi_o :
                    (valid_i && !busy_o && op_i == 3'b101) ? lo_o : '0;
  assign a_mag = (sgn_op & a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_in_mag = (sgn_op & b_i[WIDTH-1]) ? -b_i : b_i;
  assign add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
  assign trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b_mag};
  assign acc_nx = !is_div ? {add_sum, acc[WIDTH-1:1]} :
                  trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} :
                  {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign rem_f = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign quo_f = (neg_a ^ neg_b) && !b_zero ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign fixed = is_div ? {rem_f, quo_f} : (neg_a ^ neg_b) ? -acc : acc;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? RUN : IDLE) :
               kill_i ? IDLE :
               state == RUN ? (cnt == CNT_W'(1) ? FIX : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      hi_o <= '0;
      lo_o <= '0;
      done_o <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      done_o <= commit;
      if (start) begin
        acc <= {{WIDTH{1'b0}}, a_mag};
        b_mag <= b_in_mag;
        is_div <= op_i[1];
        neg_a <= sgn_op & a_i[WIDTH-1];
        neg_b <= sgn_op & b_i[WIDTH-1];
        b_zero <= b_i == '0;
        cnt <= CNT_W'(WIDTH);
      end else if (state == RUN) begin
        acc <= acc_nx;
        cnt <= cnt - CNT_W'(1);
      end
      if (commit) begin
        hi_o <= fixed[2*WIDTH-1:WIDTH];
        lo_o <= fixed[WIDTH-1:0];
      end else if (idle_issue && op_i == 3'b110) begin
        hi_o <= a_i;
      end else if (idle_issue && op_i == 3'b111) begin
        lo_o <= a_i;
      end
    end
  end
endmodule
